// File: rtl/instr_fetch_unit_if.sv
// Bus bundle for the instruction fetch unit: byte-wide instruction memory
// port on one side, instruction word handshake toward the CPU decoder on
// the other, plus the architectural PC and retired-instruction count.
interface instr_fetch_unit_if;
  // instruction memory side
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  // CPU decoder side
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic [31:0] pc;
  logic [31:0] instr_count;

  // fetch unit view
  modport master (
    output mem_req, mem_addr, instr, instr_valid, pc, instr_count,
    input  mem_ack, mem_rdata, instr_ready, branch_taken, branch_offset
  );

  // memory + CPU view
  modport slave (
    input  mem_req, mem_addr, instr, instr_valid, pc, instr_count,
    output mem_ack, mem_rdata, instr_ready, branch_taken, branch_offset
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch engine: reads four big-endian bytes per instruction
// from a byte-wide memory, holds the assembled word for the decoder, and
// advances the PC sequentially or to a branch target on consume.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | one cycle after reset; no request outstanding
// FETCH | requesting byte fetch_pc+byte_idx, waiting for mem_ack
// HOLD  | instr valid, waiting for the decoder to consume it
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst_n,
  instr_fetch_unit_if.master bus
);

  // Word-aligned start address; the low two bits of RESET_PC are dropped.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q,       state_d;
  logic [1:0]  byte_idx_q,    byte_idx_d;
  logic [31:0] fetch_pc_q,    fetch_pc_d;
  logic [23:0] asm_buf_q,     asm_buf_d;
  logic [31:0] instr_q,       instr_d;
  logic [31:0] instr_count_q, instr_count_d;

  logic [31:0] seq_pc;
  logic [31:0] branch_pc;

  // Next-PC candidates; the shift drops the top two offset bits (mod 2^32).
  always_comb begin
    seq_pc    = fetch_pc_q + 32'd4;
    branch_pc = seq_pc + (bus.branch_offset << 2);
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      byte_idx_q    <= 2'd0;
      fetch_pc_q    <= RESET_PC_ALIGNED;
      asm_buf_q     <= 24'd0;
      instr_q       <= 32'd0;
      instr_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      fetch_pc_q    <= fetch_pc_d;
      asm_buf_q     <= asm_buf_d;
      instr_q       <= instr_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Next-state and datapath update; everything holds unless an event fires.
  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    fetch_pc_d    = fetch_pc_q;
    asm_buf_d     = asm_buf_q;
    instr_d       = instr_q;
    instr_count_d = instr_count_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        if (bus.mem_ack) begin
          case (byte_idx_q)
            2'd0: asm_buf_d[23:16] = bus.mem_rdata;
            2'd1: asm_buf_d[15:8]  = bus.mem_rdata;
            2'd2: asm_buf_d[7:0]   = bus.mem_rdata;
            default: begin
              // Final byte: the word becomes visible in one step.
              instr_d = {asm_buf_q, bus.mem_rdata};
              state_d = HOLD;
            end
          endcase
          byte_idx_d = byte_idx_q + 2'd1;
        end
      end

      HOLD: begin
        if (bus.instr_ready) begin
          fetch_pc_d    = bus.branch_taken ? branch_pc : seq_pc;
          instr_count_d = instr_count_q + 32'd1;
          state_d       = FETCH;
        end
      end

      default: begin
        state_d    = IDLE;
        byte_idx_d = 2'd0;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.mem_req     = (state_q == FETCH);
    bus.mem_addr    = fetch_pc_q + {30'd0, byte_idx_q};
    bus.instr_valid = (state_q == HOLD);
    bus.instr       = instr_q;
    bus.pc          = fetch_pc_q;
    bus.instr_count = instr_count_q;
  end

endmodule
